ctr_bus_sequencer: RTL

Bus-master sequencer that sits directly upstream of the programmable up/down counter and drives its chip-select/strobe register bus. It accepts one counting job per valid/ready handshake, writes the load, limit and control registers, pulses `start`, waits for end-of-count or error, reads back status, and returns one response per job.

---
 rtl/ctr_pkg.sv | 24 ++
 rtl/seq_cycle_timer.sv | 27 ++
 rtl/ctr_bus_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - register map, control bits and state type for the counter bus sequencer
package ctr_pkg;

    localparam logic [1:0] CTR_A_LOAD  = 2'd0;
    localparam logic [1:0] CTR_A_LIMIT = 2'd1;
    localparam logic [1:0] CTR_A_CTRL  = 2'd2;
    localparam logic [1:0] CTR_A_STAT  = 2'd3;

    localparam int CTRL_DIR = 0;
    localparam int CTRL_EN  = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        START,
        WAIT,
        RD_SETUP,
        RD_STROBE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/seq_cycle_timer.sv
// rtl/seq_cycle_timer.sv - loadable saturating down-counter shared by strobe and timeout timing
module seq_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ctr_bus_sequencer.sv
// rtl/ctr_bus_sequencer.sv - runs one counter job per request: three register writes, start, wait, status read
module ctr_bus_sequencer
    import ctr_pkg::*;
#(
    parameter int WR_PULSE = 2,
    parameter int RD_PULSE = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_load,
    input  logic [7:0] req_limit,
    input  logic       req_dir,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_status,
    output logic [7:0] resp_count,
    output logic       resp_timeout,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic [1:0] a,
    output logic [7:0] din,
    output logic       start,
    input  logic [7:0] dout,
    input  logic       err,
    input  logic       ec,
    input  logic [7:0] count
);

    localparam int PMAX = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
    localparam int TMAX = (PMAX > TIMEOUT) ? PMAX : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    seq_state_t    state, state_n;
    logic [1:0]    widx, widx_n;
    logic [7:0]    job_limit;
    logic          job_dir;
    logic [7:0]    ctrl_byte, wr_data;
    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic          wait_end, wait_abort;

    seq_cycle_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign req_ready = (state == IDLE);

    // The load write only ever starts on the accept edge, so it takes req_load straight from the port.
    always_comb begin
        ctrl_byte           = '0;
        ctrl_byte[CTRL_EN]  = 1'b1;
        ctrl_byte[CTRL_DIR] = job_dir;
        case (widx_n)
            CTR_A_LOAD:  wr_data = req_load;
            CTR_A_LIMIT: wr_data = job_limit;
            default:     wr_data = ctrl_byte;
        endcase
    end

    always_comb begin
        state_n    = state;
        widx_n     = widx;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        wait_end   = 1'b0;
        wait_abort = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n = WR_SETUP;
                    widx_n  = CTR_A_LOAD;
                end
            end
            WR_SETUP: begin
                state_n  = WR_STROBE;
                tmr_load = 1'b1;
                tmr_val  = TW'(WR_PULSE - 1);
            end
            WR_STROBE: begin
                if (tmr_zero) state_n = WR_HOLD;
                else          tmr_dec = 1'b1;
            end
            WR_HOLD: begin
                if (widx == CTR_A_CTRL) begin
                    state_n = START;
                end else begin
                    state_n = WR_SETUP;
                    widx_n  = widx + 2'd1;
                end
            end
            START: begin
                state_n  = WAIT;
                tmr_load = 1'b1;
                tmr_val  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
            end
            WAIT: begin
                if (ec || err) begin
                    wait_end = 1'b1;
                    state_n  = RD_SETUP;
                end else if (TIMEOUT > 0 && tmr_zero) begin
                    wait_end   = 1'b1;
                    wait_abort = 1'b1;
                    state_n    = RD_SETUP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RD_SETUP: begin
                state_n  = RD_STROBE;
                tmr_load = 1'b1;
                tmr_val  = TW'(RD_PULSE - 1);
            end
            RD_STROBE: begin
                if (tmr_zero) state_n = DONE;
                else          tmr_dec = 1'b1;
            end
            DONE: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            widx         <= CTR_A_LOAD;
            job_limit    <= '0;
            job_dir      <= 1'b0;
            ncs          <= 1'b1;
            nwr          <= 1'b1;
            nrd          <= 1'b1;
            start        <= 1'b0;
            a            <= CTR_A_LOAD;
            din          <= '0;
            resp_valid   <= 1'b0;
            resp_status  <= '0;
            resp_count   <= '0;
            resp_timeout <= 1'b0;
        end else begin
            state      <= state_n;
            widx       <= widx_n;
            ncs        <= !(state_n inside {WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE});
            nwr        <= (state_n != WR_STROBE);
            nrd        <= (state_n != RD_STROBE);
            start      <= (state_n == START);
            resp_valid <= (state_n == DONE);
            if (state == IDLE && req_valid) begin
                job_limit <= req_limit;
                job_dir   <= req_dir;
            end
            if (state_n == WR_SETUP) begin
                a   <= widx_n;
                din <= wr_data;
            end else if (state_n == RD_SETUP) begin
                a <= CTR_A_STAT;
            end
            if (wait_end) begin
                resp_count   <= count;
                resp_timeout <= wait_abort;
            end
            if (state == RD_STROBE && tmr_zero) begin
                resp_status <= dout;
            end
        end
    end

endmodule
